// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler for the four Nexys Starship lanes: paced one-hot grants, kills, score, level.
// Define NEXYS_SPAWN_LFSR_EN to offset the round-robin search start with a 16-bit LFSR.
//
// state | meaning
// IDLE  | waiting for play_flag from the top-level game FSM
// RUN   | game live: spawning monsters, counting kills
// OVER  | a lane reported gameover; broadcast until play_flag drops
module nexys_starship_spawn_sched #(
    parameter int BASE_INTERVAL   = 8,
    parameter int MIN_INTERVAL    = 2,
    parameter int KILLS_PER_LEVEL = 4,
    parameter int MAX_LEVEL       = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_tick,
    input  logic       play_flag,
    input  logic [3:0] lane_empty,
    input  logic [3:0] lane_monster,
    input  logic [3:0] lane_gameover,
    output logic [3:0] lane_random,
    output logic       gameover_ctrl,
    output logic [2:0] level,
    output logic [7:0] score,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Over
);
    localparam int            CW     = $clog2(BASE_INTERVAL + 2);
    localparam logic [CW-1:0] BASE_C = CW'(BASE_INTERVAL);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_INTERVAL);
    localparam logic [7:0]    KPL8   = 8'(KILLS_PER_LEVEL);
    localparam logic [2:0]    MAXL3  = 3'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_OVER = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt, cnt_eff, interval;
    logic [1:0]    rr_ptr, start, pick_idx;
    logic          pick_vld;
    logic [3:0]    elig, mon_q, mon_qq, kill_vec;
    logic [2:0]    active, cap, kills;
    logic [8:0]    score_sum;
    logic [7:0]    kil, kil_sum;
    logic          level_up, kill_en, grant_vld, enter_run, spawn;

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (play_flag)      state_nxt = S_RUN;
            S_RUN:   if (|lane_gameover) state_nxt = S_OVER;
            S_OVER:  if (!play_flag)     state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    assign enter_run = (state == S_IDLE) && play_flag;
    assign q_Idle    = (state == S_IDLE);
    assign q_Run     = (state == S_RUN);
    assign q_Over    = (state == S_OVER);

    always_comb begin
        if (BASE_C > MIN_C + CW'(level)) interval = BASE_C - CW'(level);
        else                              interval = MIN_C;
    end

    // A 3-bit level tops out at 1 + 7/2 = 4, so the cap of 4 lanes needs no clamp.
    assign cap    = {1'b0, level[2:1]} + 3'd1;
    assign active = {2'b0, lane_monster[0]} + {2'b0, lane_monster[1]}
                  + {2'b0, lane_monster[2]} + {2'b0, lane_monster[3]};
    assign elig   = lane_empty & ~lane_monster;

`ifdef NEXYS_SPAWN_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge Clk) begin
        if (Reset)           lfsr <= 16'hACE1;
        else if (timer_tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign start = rr_ptr + lfsr[1:0];
`else
    assign start = rr_ptr;
`endif

    always_comb begin : search
        logic [1:0] idx;
        idx      = 2'd0;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!pick_vld && elig[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign grant_vld = |lane_random;
    assign cnt_eff   = cnt + CW'(timer_tick);
    // Gameover on the same cycle suppresses the spawn.
    assign spawn     = (state == S_RUN) && !grant_vld && !(|lane_gameover)
                     && (cnt_eff >= interval) && (active < cap) && pick_vld;

    assign kill_en   = (state == S_RUN) && !(|lane_gameover);
    assign kill_vec  = kill_en ? (mon_qq & ~mon_q) : 4'b0000;
    assign kills     = {2'b0, kill_vec[0]} + {2'b0, kill_vec[1]}
                     + {2'b0, kill_vec[2]} + {2'b0, kill_vec[3]};
    assign score_sum = {1'b0, score} + {6'b0, kills};
    assign kil_sum   = kil + {5'b0, kills};
    assign level_up  = (kil_sum >= KPL8);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lane_random   <= 4'b0000;
            gameover_ctrl <= 1'b0;
            rr_ptr        <= 2'd0;
            cnt           <= '0;
            mon_q         <= 4'b0000;
            mon_qq        <= 4'b0000;
        end else begin
            gameover_ctrl <= (state_nxt == S_OVER);
            mon_q         <= lane_monster;
            mon_qq        <= mon_q;

            if (state_nxt != S_RUN)               lane_random <= 4'b0000;
            else if (spawn)                       lane_random <= 4'b0001 << pick_idx;
            else if (|(lane_random & lane_monster)) lane_random <= 4'b0000;

            if (spawn) rr_ptr <= pick_idx + 2'd1;

            // Counter saturates at the interval while cap or eligibility blocks a spawn.
            if (enter_run || spawn)
                cnt <= '0;
            else if ((state == S_RUN) && !grant_vld && timer_tick && (cnt < interval))
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || enter_run) begin
            score <= 8'd0;
            level <= 3'd0;
            kil   <= 8'd0;
        end else begin
            score <= score_sum[8] ? 8'hFF : score_sum[7:0];
            kil   <= level_up ? (kil_sum - KPL8) : kil_sum;
            if (level_up && (level < MAXL3)) level <= level + 3'd1;
        end
    end

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Bench for nexys_starship_spawn_sched: directed scenarios plus randomized lane traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_nexys_starship_spawn_sched;
    localparam int BASE = 8;
    localparam int MINI = 2;
    localparam int KPL  = 4;
    localparam int MAXL = 7;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       timer_tick = 1'b0;
    logic       play_flag = 1'b0;
    logic [3:0] lane_empty = 4'hF;
    logic [3:0] lane_monster = 4'h0;
    logic [3:0] lane_gameover = 4'h0;
    logic [3:0] lane_random;
    logic       gameover_ctrl;
    logic [2:0] level;
    logic [7:0] score;
    logic       q_Idle, q_Run, q_Over;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 run, 2 over; grant is a lane index or -1.
    int          m_st = 0, m_cnt = 0, m_grant = -1, m_rr = 0;
    int          m_level = 0, m_score = 0, m_kil = 0;
    logic [3:0]  m_h1 = 4'h0, m_h2 = 4'h0;
    logic [15:0] m_lfsr = 16'hACE1;

    nexys_starship_spawn_sched #(
        .BASE_INTERVAL(BASE), .MIN_INTERVAL(MINI),
        .KILLS_PER_LEVEL(KPL), .MAX_LEVEL(MAXL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .timer_tick(timer_tick), .play_flag(play_flag),
        .lane_empty(lane_empty), .lane_monster(lane_monster), .lane_gameover(lane_gameover),
        .lane_random(lane_random), .gameover_ctrl(gameover_ctrl), .level(level), .score(score),
        .q_Idle(q_Idle), .q_Run(q_Run), .q_Over(q_Over)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin : model
        int nst, kills, act, cap, ivl, start, pick;
        logic [3:0] elig;
        if (Reset) begin
            m_st = 0; m_cnt = 0; m_grant = -1; m_rr = 0;
            m_level = 0; m_score = 0; m_kil = 0;
            m_h1 = 4'h0; m_h2 = 4'h0; m_lfsr = 16'hACE1;
        end else begin
            nst = m_st;
            if (m_st == 0 && play_flag)               nst = 1;
            else if (m_st == 1 && lane_gameover != 0) nst = 2;
            else if (m_st == 2 && !play_flag)         nst = 0;

            kills = (m_st == 1 && lane_gameover == 0) ? $countones(m_h2 & ~m_h1) : 0;
            ivl   = BASE - m_level;
            if (ivl < MINI) ivl = MINI;
            cap   = 1 + m_level / 2;
            if (cap > 4) cap = 4;
            act   = $countones(lane_monster);
            elig  = lane_empty & ~lane_monster;
`ifdef NEXYS_SPAWN_LFSR_EN
            start = (m_rr + int'(m_lfsr[1:0])) % 4;
`else
            start = m_rr;
`endif
            if (m_st == 1 && nst == 1 && m_grant < 0 && (m_cnt + int'(timer_tick)) >= ivl
                && act < cap && elig != 0) begin
                pick = start;
                while (!elig[pick]) pick = (pick + 1) % 4;
                m_grant = pick;
                m_rr    = (pick + 1) % 4;
                m_cnt   = 0;
            end else begin
                if (m_st == 1 && m_grant < 0 && timer_tick) m_cnt++;
                if (nst != 1) m_grant = -1;
                else if (m_grant >= 0 && lane_monster[m_grant]) m_grant = -1;
            end

            if (m_st == 0 && nst == 1) begin
                m_cnt = 0; m_grant = -1; m_level = 0; m_score = 0; m_kil = 0;
            end else if (kills > 0) begin
                m_score += kills;
                if (m_score > 255) m_score = 255;
                m_kil += kills;
                while (m_kil >= KPL) begin
                    m_kil -= KPL;
                    if (m_level < MAXL) m_level++;
                end
            end

            if (timer_tick) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_st = nst;
            m_h2 = m_h1;
            m_h1 = lane_monster;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic [3:0] er;
        er = (m_grant < 0) ? 4'd0 : (4'd1 << m_grant);
        check_val("m_lane_random", 32'(lane_random), 32'(er));
        check_val("m_gameover", 32'(gameover_ctrl), 32'(m_st == 2));
        check_val("m_level", 32'(level), 32'(m_level));
        check_val("m_score", 32'(score), 32'(m_score));
        check_val("m_state", 32'({q_Over, q_Run, q_Idle}), 32'({m_st == 2, m_st == 1, m_st == 0}));
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
        check_cycle();
    endtask

    task automatic ticks(input int n);
        timer_tick = 1'b1;
        repeat (n) step();
        timer_tick = 1'b0;
    endtask

    task automatic start_game();
        Reset = 1'b1; play_flag = 1'b0; timer_tick = 1'b0;
        lane_empty = 4'hF; lane_monster = 4'h0; lane_gameover = 4'h0;
        step();
        Reset = 1'b0; play_flag = 1'b1;
        step();
        check_val("run_entry", 32'(q_Run), 32'd1);
    endtask

    task automatic kill_pair(input logic [3:0] pat);
        lane_monster = pat; step();
        lane_monster = 4'h0; step();
    endtask

    initial begin
        // Reset values
        Reset = 1'b1;
        step(); step();
        check_val("rst_rand", 32'(lane_random), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_go", 32'(gameover_ctrl), 32'd0);
        check_val("rst_idle", 32'(q_Idle), 32'd1);

        // First grant after 8 ticks, handshake, cap 1 blocks second spawn
        start_game();
        ticks(7);
        check_val("pre_grant", 32'(lane_random), 32'd0);
        ticks(1);
        check_val("grant0", 32'(lane_random), 32'b0001);
        lane_monster[0] = 1'b1; lane_empty[0] = 1'b0;
        step();
        check_val("grant_clr", 32'(lane_random), 32'd0);
        ticks(8);
        check_val("cap_block", 32'(lane_random), 32'd0);
        lane_monster[0] = 1'b0; lane_empty[0] = 1'b1;
        step();
        check_val("grant1", 32'(lane_random), 32'b0010);
        step();
        check_val("first_kill", 32'(score), 32'd1);

        // Four kills advance to level 1, interval 7
        start_game();
        repeat (4) kill_pair(4'b0001);
        step(); step();
        check_val("lvl1_score", 32'(score), 32'd4);
        check_val("lvl1_level", 32'(level), 32'd1);
        ticks(6);
        check_val("ivl7_pre", 32'(lane_random), 32'd0);
        ticks(1);
        check_val("ivl7_grant", 32'(lane_random), 32'b0001);

        // Two simultaneous kills
        start_game();
        lane_monster = 4'b0011; step();
        lane_monster = 4'b0000; step(); step();
        check_val("dual_kill", 32'(score), 32'd2);

        // Gameover with a grant held on lane 2
        start_game();
        for (int g = 0; g < 2; g++) begin
            ticks(8);
            lane_monster[g] = 1'b1; lane_empty[g] = 1'b0; step();
            lane_monster[g] = 1'b0; lane_empty[g] = 1'b1;
        end
        ticks(8);
        check_val("grant2", 32'(lane_random), 32'b0100);
        lane_gameover = 4'b0010; step();
        check_val("go_ctrl", 32'(gameover_ctrl), 32'd1);
        check_val("go_rand", 32'(lane_random), 32'd0);
        check_val("go_over", 32'(q_Over), 32'd1);
        lane_gameover = 4'b0000; play_flag = 1'b0; step();
        check_val("go_idle", 32'(q_Idle), 32'd1);
        check_val("go_clear", 32'(gameover_ctrl), 32'd0);

        // Level saturation, minimum interval, score saturation
        start_game();
        repeat (7) kill_pair(4'hF);
        step(); step();
        check_val("lvl7", 32'(level), 32'd7);
        check_val("score28", 32'(score), 32'd28);
        ticks(1);
        check_val("ivl2_pre", 32'(lane_random), 32'd0);
        ticks(1);
        check_val("ivl2_grant", 32'(lane_random), 32'b0001);
        repeat (56) kill_pair(4'hF);
        kill_pair(4'b0011);
        step(); step();
        check_val("score254", 32'(score), 32'd254);
        kill_pair(4'b0111);
        step(); step();
        check_val("score255", 32'(score), 32'd255);
        check_val("lvl7_hold", 32'(level), 32'd7);

        // Reset mid-RUN with a grant held
        start_game();
        ticks(8);
        check_val("pre_rst_grant", 32'(lane_random), 32'b0001);
        Reset = 1'b1; step();
        check_val("mid_rst_rand", 32'(lane_random), 32'd0);
        check_val("mid_rst_idle", 32'(q_Idle), 32'd1);
        check_val("mid_rst_go", 32'(gameover_ctrl), 32'd0);
        Reset = 1'b0;

        // Randomized lane traffic against the model
        lane_monster = 4'h0; lane_empty = 4'hF; lane_gameover = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_monster[i]) begin
                    if ($urandom_range(0, 5) == 0) lane_monster[i] = 1'b0;
                end else if (m_grant == i && $urandom_range(0, 1) == 1) begin
                    lane_monster[i] = 1'b1;
                end else if ($urandom_range(0, 60) == 0) begin
                    lane_monster[i] = 1'b1;
                end
                lane_empty[i] = !lane_monster[i] && ($urandom_range(0, 7) != 0);
            end
            timer_tick    = ($urandom_range(0, 2) == 0);
            lane_gameover = ($urandom_range(0, 150) == 0) ? (4'd1 << $urandom_range(0, 3)) : 4'd0;
            if (m_st == 2 && $urandom_range(0, 3) == 0)      play_flag = 1'b0;
            else if (m_st == 0 && $urandom_range(0, 3) == 0) play_flag = 1'b1;
            Reset = ($urandom_range(0, 500) == 0);
            step();
        end
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nexys_starship_spawn_sched.md
# nexys_starship_spawn_sched

Central monster scheduler for the four Nexys Starship lane controllers (left, right, up, down). It decides when and in which lane a monster spawns, and issues one-hot spawn grants that drive each lane FSM's `*_random` input. It tracks kills, score and difficulty level, and aggregates per-lane gameover into the shared `gameover_ctrl`. It sits between the top-level game FSM (`play_flag`) and the lane FSM instances.

## Interface
Parameters:
- `BASE_INTERVAL`, 8: spawn interval in ticks at level 0.
- `MIN_INTERVAL`, 2: floor on the spawn interval.
- `KILLS_PER_LEVEL`, 4: kills needed to advance one level.
- `MAX_LEVEL`, 7: level saturation value (3-bit level).

Ports:
- `Clk` in 1: system clock; single clock domain.
- `Reset` in 1: synchronous, active-high reset.
- `timer_tick` in 1: one-`Clk`-cycle game-time strobe.
- `play_flag` in 1: game-start request from the top FSM.
- `lane_empty` in 4: lane FSM is in EMPTY; bit 0 = left, 1 = right, 2 = up, 3 = down.
- `lane_monster` in 4: lane monster-present flags.
- `lane_gameover` in 4: per-lane gameover flags.
- `lane_random` out 4: one-hot spawn grant; all zero when idle.
- `gameover_ctrl` out 1: broadcast gameover to all lanes.
- `level` out 3: current difficulty level.
- `score` out 8: kill count, saturating.
- `q_Idle`, `q_Run`, `q_Over` out 1 each: one-hot state outputs.

## Operation
- State machine, one-hot:
  - IDLE → RUN when `play_flag` = 1.
  - RUN → OVER when any `lane_gameover` bit = 1.
  - OVER → IDLE when `play_flag` = 0.
- Entering RUN from IDLE clears `score`, `level`, kill-in-level count, interval counter and grant.
- Interval:
  - `interval = max(BASE_INTERVAL − level, MIN_INTERVAL)`.
  - The interval counter increments on `timer_tick` in RUN while no grant is outstanding.
- Monster cap: `cap = min(1 + level/2, 4)`.
- Active count = popcount(`lane_monster`).
- Eligible lane i: `lane_empty[i]` and not `lane_monster[i]`.
- Spawn condition, evaluated in RUN with no grant outstanding: counter ≥ interval, active < cap, and at least one lane eligible.
  - On spawn: pick the first eligible lane at or after `rr_ptr` (circular search).
  - Assert that lane's `lane_random` bit and clear the counter.
  - Set `rr_ptr` to the granted lane + 1 (mod 4).
  - If the condition fails only on cap or eligibility, the counter holds at its value (no wrap) until spawn is possible.
- Grant handshake:
  - `lane_random[g]` holds high until `lane_monster[g]` is sampled 1; it clears the next cycle.
  - Only one grant is outstanding at a time.
  - Leaving RUN clears the grant immediately (registered, next cycle).
- Kill detection:
  - A kill is a falling edge of `lane_monster[i]` (previous-cycle register 1, current 0) in RUN with all `lane_gameover` = 0.
  - Simultaneous kills in one cycle count individually (0–4 per cycle).
- Score adds the kill count and saturates at 255.
- Level:
  - The kill-in-level counter accumulates kills; each time it reaches ≥ `KILLS_PER_LEVEL`, subtract `KILLS_PER_LEVEL` and increment `level`.
  - `level` saturates at `MAX_LEVEL`; kills still add to score.
- `gameover_ctrl` = 1 in OVER and on the cycle of RUN→OVER detection; 0 otherwise.
- Reset values:
  - State IDLE.
  - `lane_random` = 0, `gameover_ctrl` = 0, `level` = 0, `score` = 0.
  - `rr_ptr` = 0, counter = 0, LFSR = 16'hACE1.

## Timing
- All outputs are registered.
- `lane_random` asserts 1 `Clk` after the tick that satisfies the spawn condition.
- Grant clears 1 cycle after `lane_monster[g]` is seen high.
- `score` and `level` update 1 cycle after the `lane_monster` falling edge is sampled, which is 2 cycles after the lane drops its flag.
- RUN→OVER: `gameover_ctrl` is high 1 cycle after `lane_gameover` is sampled.
- Reset asserted mid-RUN returns all registers to reset values on the next `Clk` edge, with an outstanding grant dropped.
- Gameover and spawn in the same cycle: gameover wins; no grant is issued.

## Configuration
- `NEXYS_SPAWN_LFSR_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) advances every `timer_tick`.
  - At each spawn, the search start is `(rr_ptr + lfsr[1:0]) mod 4` instead of `rr_ptr`.
- Undefined:
  - No LFSR logic is built.
  - The search starts at `rr_ptr`, giving a pure round-robin order.

## Test plan
- Reset, `play_flag` = 1, all lanes empty, macro undefined, 8 ticks → grant 4'b0001; `lane_monster[0]` = 1 → grant 0 next cycle; next spawn after 8 more ticks on 4'b0010 only if cap allows (level 0, cap 1: no spawn until lane 0 clears).
- Lane 0 monster drops 1→0 four times → `score` = 4, `level` = 1, interval 7, cap 1.
- `lane_monster` 4'b0011 → 4'b0000 in one cycle → `score` += 2.
- Grant outstanding on lane 2, `lane_gameover[1]` = 1 → `gameover_ctrl` = 1 next cycle, `lane_random` = 0, state OVER; `play_flag` = 0 → IDLE.
- Score preloaded to 254 via kills, 3 simultaneous kills → `score` = 255; level saturates at 7 after 28 kills, interval = 2.
- `Reset` pulse mid-RUN with a grant held → all outputs 0, `q_Idle` = 1 next cycle.
